// File: rtl/booth_pkg.sv
// booth_pkg: shared FSM state, Booth operation encoding and triplet-to-operation mapping
package booth_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [2:0] {OP_ZERO, OP_PM, OP_P2M, OP_NM, OP_N2M} op_t;
    function automatic op_t booth_op(input logic [2:0] t);
        return (t == 3'b000 || t == 3'b111) ? OP_ZERO :
               (t == 3'b011)                ? OP_P2M  :
               (t == 3'b100)                ? OP_N2M  :
               t[2]                         ? OP_NM   : OP_PM;
    endfunction
endpackage

// File: rtl/booth_r4_enc.sv
// booth_r4_enc: radix-4 Booth recoder; trip = {q[1],q[0],q_m1}, m = sign-extended multiplicand, addend = selected signed multiple of m
module booth_r4_enc
    import booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [2:0]   trip,
    input  logic [N+1:0] m,
    output logic [N+1:0] addend
);
    op_t op;
    // m is sign-extended by two bits, so doubling it and negating it both fit in N+2 bits
    always_comb begin
        op     = booth_op(trip);
        addend = (op == OP_PM)  ? m :
                 (op == OP_P2M) ? {m[N:0], 1'b0} :
                 (op == OP_NM)  ? -m :
                 (op == OP_N2M) ? -{m[N:0], 1'b0} : '0;
    end
endmodule

// File: rtl/booth_r4_seq_mult.sv
// booth_r4_seq_mult: sequential signed radix-4 Booth multiplier with start/done handshake
// Ports: clk, clr_n (async active-low reset), start, a/b (signed operands),
//        busy (RUN or DONE), done (one-cycle pulse), product (2N-bit signed, held until next done)
module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = $clog2(N/2) + 1
) (
    input  logic           clk,
    input  logic           clr_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);
    state_t state, nxt;
    logic [N+1:0] m, acc, addend, sum;
    logic [N-1:0] q;
    logic q_m1, last;
    logic [CW-1:0] count;

    booth_r4_enc #(.N(N)) u_enc (.trip({q[1:0], q_m1}), .m(m), .addend(addend));

    assign sum  = acc + addend;
    assign last = count == CW'(N/2 - 1);

    always_ff @(posedge clk or negedge clr_n)
        if (!clr_n) state <= IDLE;
        else        state <= nxt;

    always_comb begin
        nxt  = state;
        nxt  = (state == IDLE) ? (start ? RUN : IDLE) :
               (state == RUN)  ? (last ? DONE : RUN) : IDLE;
        busy = state != IDLE;
        done = state == DONE;
    end

    // {acc,q,q_m1} is shifted arithmetically right by two after each addition;
    // the final shift is also written straight into product so it is valid with done
    always_ff @(posedge clk or negedge clr_n)
        if (!clr_n) begin
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            count   <= '0;
            product <= '0;
        end else if (state == IDLE && start) begin
            m     <= {{2{a[N-1]}}, a};
            acc   <= '0;
            q     <= b;
            q_m1  <= 1'b0;
            count <= '0;
        end else if (state == RUN) begin
            acc   <= {{2{sum[N+1]}}, sum[N+1:2]};
            q     <= {sum[1:0], q[N-1:2]};
            q_m1  <= q[1];
            count <= count + CW'(1);
            if (last) product <= {sum[N+1:2], sum[1:0], q[N-1:2]};
        end
endmodule

// File: doc/booth_r4_seq_mult.md
Name: booth_r4_seq_mult

Overview:
- Sequential signed Radix-4 Booth multiplier: FSM controller plus a shared partial-product accumulator/shift register built from clocked registers.
- Retires 2 multiplier bits per cycle, so an N×N product takes N/2 iteration cycles.
- Used as a multi-cycle arithmetic resource behind a start/done handshake.
- Replaces N/2 parallel partial-product adders with one adder that is reused every cycle.

Parameters:
- N, 8, operand width in bits (two's complement). Must be even and ≥ 4.
- CW, $clog2(N/2)+1, iteration counter width (derived).

Ports:
- clk  in  1  rising-edge clock
- clr_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- a  in  N  multiplicand (signed); captured when start is accepted
- b  in  N  multiplier (signed); captured when start is accepted
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; product valid
- product  out  2N  signed result; holds its value until the next done

Behaviour:
- Reset: clk is one clock; clr_n is asynchronous and active-low. While clr_n=0: state=IDLE, busy=0, done=0, product=0, internal acc/q/q_m1/count=0.
- Reset asserted mid-operation aborts immediately. No done pulse is produced. The first start after clr_n rises is accepted normally.
- Internal registers:
  - M: N+2 bits, sign-extended a.
  - acc: N+2 bits, upper partial product.
  - q: N bits, multiplier/low product.
  - q_m1: 1 bit, appended LSB.
  - count: CW bits.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0.
  - On start=1 at a clock edge: M←sext(a), acc←0, q←b, q_m1←0, count←0, go to RUN.
- RUN (N/2 cycles):
  - Encode triplet {q[1],q[0],q_m1}:
    - 000/111 → +0
    - 001/010 → +M
    - 011 → +2M
    - 100 → −2M
    - 101/110 → −M
  - sum = acc + op, computed in N+2 bits; wrap-free by construction.
  - Arithmetic right shift by 2 of {sum, q, q_m1}: sign of sum replicated into the top 2 bits, q_m1←q[1] of the pre-shift q.
  - count←count+1.
  - When count = N/2−1, go to DONE after this update.
- DONE (1 cycle):
  - done=1, busy=1.
  - product←{acc[N−1:0], q}, registered on entry to DONE so it is visible in the same cycle done=1.
  - Then go to IDLE.
- Latency: start accepted at edge E0 → done high during the cycle after edge E0+N/2 (N/2+1 edges). N=8: done in cycle 5 after acceptance.
- start in RUN or DONE is ignored, not queued. The requester must re-assert it in IDLE.
- a and b are only sampled at acceptance; later changes have no effect.
- Back-to-back throughput: one result per N/2+2 cycles (start held high continuously is accepted in the IDLE cycle that follows DONE).
- Full-range operands (−2^(N−1) × −2^(N−1)) are exact. The 2N-bit product never overflows.
- done is never high for two consecutive cycles.

Decomposition:
- Shared package booth_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Booth op enum {OP_ZERO, OP_PM, OP_P2M, OP_NM, OP_N2M}.
  - Function/constant for the triplet → op mapping.
- Natural sub-module: booth_r4_enc. Purely combinational: 3-bit triplet plus M in, N+2-bit signed addend out. Instantiated once by the controller.

Test Plan:
- N=8, a=7, b=3, start pulse → busy high for 5 cycles, done pulses at cycle 5, product=21 (0x0015); busy=0 the next cycle.
- a=−128, b=−128 → product=16384 (0x4000). a=−128, b=127 → product=−16256 (0xC080). a=−1, b=−1 → product=1.
- a=0x55, b=0 and a=0, b=−128 → product=0; done timing is unchanged (data-independent latency).
- a=5, b=6 accepted; in cycle 2 drive start=1 with a=9, b=9 → second request ignored, product=30, exactly one done.
- a=12, b=−11 accepted; pull clr_n low in cycle 2 → busy, done, product go to 0 immediately with no done. After release, a=−7, b=9 → product=−63 (0xFFC1).
- start held high continuously with a,b stepping through the random signed pairs → one done per 6 cycles. Every product matches the reference a*b over ≥1000 random pairs, including ±127/−128 corners.
